// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer for an SDF FFT output.
// Ping-pong banks: one frame is written while the previous one streams out.
module fft_bitrev_reorder #(
    parameter int DATA_NUM   = 1024,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         data_i_en,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic                         data_o_en,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_o_sop
);

    localparam int AW = $clog2(DATA_NUM);
    localparam logic [AW-1:0] LAST = AW'(DATA_NUM - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic signed [DATA_WIDTH-1:0] mem_a [DATA_NUM];
    logic signed [DATA_WIDTH-1:0] mem_b [DATA_NUM];

    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic [0:0]    state;

    logic wr_last;
    logic rd_issue;
    logic rd_last;
    logic other_ready;
    logic signed [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < AW; i++) begin
            wr_addr[i] = wr_cnt[AW-1-i];
        end
    end

    assign wr_last  = data_i_en && (wr_cnt == LAST);
    assign rd_issue = (state == READ) || full[rd_bank];
    assign rd_last  = rd_issue && (rd_cnt == LAST);
    assign rd_data  = rd_bank ? mem_b[rd_cnt] : mem_a[rd_cnt];

    // A frame completing into the other bank on this edge keeps READ going
    assign other_ready = full[~rd_bank] || (wr_last && (wr_bank != rd_bank));

    always_comb begin
        full_nxt = full;
        if (rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (data_i_en) begin
            if (wr_bank) begin
                mem_b[wr_addr] <= data_i;
            end else begin
                mem_a[wr_addr] <= data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (data_i_en) begin
                wr_cnt <= wr_cnt + AW'(1);
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            state   <= IDLE;
        end else if (rd_issue) begin
            rd_cnt <= rd_cnt + AW'(1);
            if (rd_last) begin
                rd_bank <= ~rd_bank;
                state   <= other_ready ? READ : IDLE;
            end else begin
                state <= READ;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_o_en  <= 1'b0;
            data_o_sop <= 1'b0;
            data_o     <= '0;
        end else begin
            data_o_en  <= rd_issue;
            data_o_sop <= rd_issue && (rd_cnt == '0);
            if (rd_issue) begin
                data_o <= rd_data;
            end
        end
    end

    // Writer overrunning a bank the reader has not drained yet
    a_no_overrun : assert property (
        @(posedge clk) disable iff (!rstn)
        !(data_i_en && full[wr_bank])
    );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed and randomised checks of the bit-reverse reorder buffer
// with DATA_NUM=16; outputs are captured at the falling edge.
module tb_fft_bitrev_reorder;

    localparam int N = 16;
    localparam int W = 64;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                data_i_en = 1'b0;
    logic signed [W-1:0] data_i = '0;
    logic                data_o_en;
    logic signed [W-1:0] data_o;
    logic                data_o_sop;

    fft_bitrev_reorder #(.DATA_NUM(N), .DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_i_en  (data_i_en),
        .data_i     (data_i),
        .data_o_en  (data_o_en),
        .data_o     (data_o),
        .data_o_sop (data_o_sop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         sop;
        int           c;
    } rec_t;

    rec_t q[$];
    int   bad_sop = 0;

    always @(negedge clk) begin
        if (data_o_en) q.push_back('{data_o, data_o_sop, cyc});
        else if (data_o_sop) bad_sop++;
    end

    int tests = 0;
    int fails = 0;
    int last_acc = 0;
    int perm [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    task automatic drive(input logic en, input logic [W-1:0] v);
        @(posedge clk);
        #1;
        data_i_en = en;
        data_i    = v;
        if (en) last_acc = cyc;
    endtask

    task automatic wait_out(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            drive(1'b0, '0);
            k++;
        end
        if (q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d outputs, need %0d", nm, q.size(), n);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (data_o_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_en: got %b need 0", data_o_en);
        end
        tests++;
        if (data_o_sop !== 1'b0) begin
            fails++;
            $display("FAIL reset_sop: got %b need 0", data_o_sop);
        end
        tests++;
        if (data_o !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h need 0", data_o);
        end
        rstn = 1'b1;
        repeat (4) drive(1'b0, '0);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL reset_quiet: got %0d outputs need 0", q.size());
        end
    endtask

    task automatic test_single_frame;
        int e;
        q.delete();
        for (int i = 0; i < N; i++) drive(1'b1, W'(i));
        wait_out(N, 40, "single");
        if (q.size() >= N) begin
            tests++;
            if (q[0].c != last_acc + 2) begin
                fails++;
                $display("FAIL single_latency: got cycle %0d need %0d", q[0].c, last_acc + 2);
            end
            for (int k = 0; k < N; k++) begin
                tests++;
                e = 0;
                if (q[k].d !== W'(perm[k])) e++;
                if (q[k].sop !== (k == 0)) e++;
                if (q[k].c != q[0].c + k) e++;
                if (e != 0) begin
                    fails++;
                    $display("FAIL single_out[%0d]: got d=%0d sop=%b c=%0d need d=%0d sop=%b c=%0d",
                             k, q[k].d, q[k].sop, q[k].c, perm[k], (k == 0), q[0].c + k);
                end
            end
        end
        repeat (5) drive(1'b0, '0);
        tests++;
        if (q.size() != N) begin
            fails++;
            $display("FAIL single_extra: got %0d outputs need %0d", q.size(), N);
        end
        tests++;
        if (data_o !== W'(15) || data_o_en !== 1'b0 || data_o_sop !== 1'b0) begin
            fails++;
            $display("FAIL single_hold: got d=%0d en=%b sop=%b need d=15 en=0 sop=0",
                     data_o, data_o_en, data_o_sop);
        end
    endtask

    task automatic test_back_to_back;
        int e;
        logic [W-1:0] x;
        q.delete();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N; i++) drive(1'b1, W'(f * 16 + i));
        wait_out(4 * N, 60, "b2b");
        if (q.size() >= 4 * N) begin
            e = 0;
            for (int k = 0; k < 4 * N; k++) begin
                x = W'((k / 16) * 16 + perm[k % 16]);
                if (q[k].d !== x || q[k].sop !== (k % 16 == 0) || q[k].c != q[0].c + k) begin
                    e++;
                    $display("FAIL b2b_out[%0d]: got d=%0d sop=%b c=%0d need d=%0d sop=%b c=%0d",
                             k, q[k].d, q[k].sop, q[k].c, x, (k % 16 == 0), q[0].c + k);
                end
            end
            tests++;
            if (e != 0) fails++;
            tests++;
            if (q[63].c != last_acc + 2 + 15) begin
                fails++;
                $display("FAIL b2b_end: got cycle %0d need %0d", q[63].c, last_acc + 17);
            end
        end
        repeat (4) drive(1'b0, '0);
    endtask

    task automatic test_gapped;
        int e;
        q.delete();
        for (int i = 0; i < N; i++) begin
            drive(1'b1, W'(100 + i));
            if (i != N - 1) drive(1'b0, W'(999));
        end
        wait_out(N, 40, "gapped");
        if (q.size() >= N) begin
            tests++;
            if (q[0].c != last_acc + 2) begin
                fails++;
                $display("FAIL gapped_latency: got cycle %0d need %0d", q[0].c, last_acc + 2);
            end
            e = 0;
            for (int k = 0; k < N; k++)
                if (q[k].d !== W'(100 + perm[k]) || q[k].sop !== (k == 0)) e++;
            tests++;
            if (e != 0) begin
                fails++;
                $display("FAIL gapped_seq: got %0d wrong outputs need 0", e);
            end
        end
        repeat (4) drive(1'b0, '0);
    endtask

    task automatic test_two_frames_gap;
        int e;
        int t1;
        q.delete();
        for (int i = 0; i < N; i++) drive(1'b1, W'(300 + i));
        t1 = last_acc;
        repeat (5) drive(1'b0, '0);
        for (int i = 0; i < N; i++) drive(1'b1, W'(400 + i));
        wait_out(2 * N, 40, "gap2");
        if (q.size() >= 2 * N) begin
            tests++;
            if (q[0].c != t1 + 2 || q[16].c != last_acc + 2) begin
                fails++;
                $display("FAIL gap2_start: got cycles %0d,%0d need %0d,%0d",
                         q[0].c, q[16].c, t1 + 2, last_acc + 2);
            end
            tests++;
            if (q[16].c <= q[15].c + 1) begin
                fails++;
                $display("FAIL gap2_bubble: got cycles %0d,%0d need a gap", q[15].c, q[16].c);
            end
            e = 0;
            for (int k = 0; k < 2 * N; k++)
                if (q[k].d !== W'((k < 16 ? 300 : 400) + perm[k % 16]) ||
                    q[k].sop !== (k % 16 == 0)) e++;
            tests++;
            if (e != 0) begin
                fails++;
                $display("FAIL gap2_seq: got %0d wrong outputs need 0", e);
            end
        end
        repeat (4) drive(1'b0, '0);
    endtask

    task automatic test_reset_mid_frame;
        int e;
        for (int i = 0; i < 8; i++) drive(1'b1, W'(500 + i));
        @(posedge clk);
        #1;
        data_i_en = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) drive(1'b0, '0);
        q.delete();
        for (int i = 0; i < N; i++) drive(1'b1, W'(200 + i));
        wait_out(N, 40, "rstmid");
        repeat (20) drive(1'b0, '0);
        tests++;
        if (q.size() != N) begin
            fails++;
            $display("FAIL rstmid_count: got %0d outputs need %0d", q.size(), N);
        end
        if (q.size() >= N) begin
            tests++;
            if (q[0].c != last_acc + 2) begin
                fails++;
                $display("FAIL rstmid_latency: got cycle %0d need %0d", q[0].c, last_acc + 2);
            end
            e = 0;
            for (int k = 0; k < N; k++)
                if (q[k].d !== W'(200 + perm[k]) || q[k].sop !== (k == 0)) e++;
            tests++;
            if (e != 0) begin
                fails++;
                $display("FAIL rstmid_seq: got %0d wrong outputs need 0", e);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] fr [16];
        logic [W-1:0] exp_q[$];
        q.delete();
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < N; i++) fr[i] = {$urandom, $urandom};
            for (int k = 0; k < N; k++) exp_q.push_back(fr[perm[k]]);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) repeat ($urandom_range(3)) drive(1'b0, '0);
                drive(1'b1, fr[i]);
            end
        end
        wait_out(100 * N, 60, "random");
        for (int k = 0; k < exp_q.size() && k < q.size(); k++) begin
            tests++;
            if (q[k].d !== exp_q[k] || q[k].sop !== (k % 16 == 0)) begin
                fails++;
                $display("FAIL random_out[%0d]: got d=%h sop=%b need d=%h sop=%b",
                         k, q[k].d, q[k].sop, exp_q[k], (k % 16 == 0));
            end
        end
        tests++;
        if (bad_sop != 0) begin
            fails++;
            $display("FAIL sop_without_en: got %0d occurrences need 0", bad_sop);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_two_frames_gap();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter DATA_NUM, default 1024: FFT frame length in samples; power of two, at least 4.
REQ-002 Parameter DATA_WIDTH, default 64: sample width; upper half is real, lower half is imaginary, both two's complement.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port data_i_en, input, 1 bit: input sample valid; driven by the last SDF stage's mul_o_en.
REQ-006 Port data_i, input, DATA_WIDTH bits, signed: input sample in bit-reversed order; driven by the last stage's mul_o.
REQ-007 Port data_o_en, output, 1 bit: output sample valid.
REQ-008 Port data_o, output, DATA_WIDTH bits, signed: output sample in natural order.
REQ-009 Port data_o_sop, output, 1 bit: high together with data_o_en on the first sample (index 0) of each output frame.

Function
REQ-010 Storage SHALL be two ping-pong banks, A and B, each DATA_NUM x DATA_WIDTH; the internal address width is AW = log2(DATA_NUM).
REQ-011 Write counter wr_cnt (AW bits) SHALL increment only on cycles with data_i_en=1 and wrap from DATA_NUM-1 to 0; gaps in data_i_en are allowed anywhere in a frame.
REQ-012 Each accepted sample SHALL be written to the current write bank at address bitrev(wr_cnt), where bit i of the address is bit AW-1-i of wr_cnt.
REQ-013 On acceptance of the sample with wr_cnt=DATA_NUM-1, the write bank's full flag SHALL set on the same edge and the write bank pointer SHALL toggle.
REQ-014 The read side SHALL have two states. IDLE: no read is issued. READ: one read is issued per cycle at address rd_cnt = 0..DATA_NUM-1.
REQ-015 IDLE -> READ SHALL occur in the first cycle in which the full flag of the read bank pointer's bank is visible as set.
REQ-016 While rd_cnt=DATA_NUM-1 is issued: the current bank's full flag SHALL clear; rd_cnt SHALL wrap to 0; the read bank pointer SHALL toggle.
REQ-017 After REQ-016, the state SHALL remain READ if the other bank's full flag is set in that same cycle (no bubble between frames); otherwise it SHALL return to IDLE.
REQ-018 Bank RAM reads SHALL be registered: data_o, data_o_en and data_o_sop SHALL appear exactly 1 cycle after the read is issued.
REQ-019 Latency: if the last input sample of a frame is accepted in cycle T, the first output (data_o_en=1, data_o_sop=1) SHALL be in cycle T+2, followed by DATA_NUM consecutive valid cycles.
REQ-020 With continuous input, the write side SHALL never reach a bank whose full flag is still set. If it does (a design error), this SHALL be detected by a simulation assertion; no hardware flag is provided.
REQ-021 A frame-ending write to bank X in the same cycle that bank Y's last read is issued SHALL be handled per REQ-017: the read side continues into bank X with no gap.
REQ-022 When data_o_en=0, data_o SHALL hold its last value and data_o_sop SHALL be 0.
REQ-023 Output SHALL be a pure permutation: no arithmetic, scaling or width change.

Reset
REQ-024 While rstn=0: wr_cnt=0, rd_cnt=0, both full flags=0, both bank pointers=A, read state=IDLE, data_o_en=0, data_o_sop=0, data_o=0.
REQ-025 Bank RAM contents are not reset. Partially written frames are discarded on reset; the first frame after reset starts at wr_cnt=0.
REQ-026 An assertion of rstn in the middle of a frame SHALL abort any output in progress from the next edge, with no further data_o_en pulses.

Verification (DATA_NUM=16, DATA_WIDTH=64)
REQ-027 Single frame: apply data_i = 0..15 contiguously (sample index as value) -> 16 outputs starting 2 cycles after the last input, in the sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with data_o_sop only on the first.
REQ-028 Four back-to-back contiguous frames -> 64 consecutive data_o_en cycles with no gap, data_o_sop every 16th cycle, and correct permutation per frame.
REQ-029 One frame with data_i_en toggling 1,0,1,0 -> same output sequence as REQ-027; output starts at T+2 relative to the last accepted sample.
REQ-030 Two frames separated by a 5-cycle idle gap -> two separate 16-cycle bursts with a gap between them; the read side returns to IDLE in between.
REQ-031 Assert rstn low after 8 input samples, release, then apply a full frame -> no output from the aborted frame; the new frame's output is correct per REQ-027.
REQ-032 Random data over 100 frames with random input gaps, checked against a reference model -> zero mismatches, and the REQ-020 assertion never fires.
